// File: rtl/iniciador_bus_rtc.sv
// Bus initiator for the RTC register port. Issues single host-commanded
// transactions or an auto-poll sweep over the nine time/date registers,
// handshaking with the responder and capturing read data.
module iniciador_bus_rtc #(
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        poll_start,
  input  logic        rsp_valid,
  input  logic [7:0]  dato_in,
  output logic        cs,
  output logic        writestrobe,
  output logic        readstrobe,
  output logic [7:0]  dir,
  output logic [7:0]  dato,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic [71:0] shadow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_GAPWAIT = 3'd5;

  // Last value of each counter; WAIT and GAPWAIT last exactly TIMEOUT / GAP cycles.
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [2:0] state;
  logic       is_write;
  logic       is_poll;
  logic [3:0] idx;
  logic [7:0] wcnt;
  logic [3:0] gcnt;

  // Register list scanned by the poll sweep: seconds..year block then 65..67.
  function automatic logic [7:0] poll_addr(input logic [3:0] k);
    case (k)
      4'd0:    poll_addr = 8'd33;
      4'd1:    poll_addr = 8'd34;
      4'd2:    poll_addr = 8'd35;
      4'd3:    poll_addr = 8'd36;
      4'd4:    poll_addr = 8'd37;
      4'd5:    poll_addr = 8'd38;
      4'd6:    poll_addr = 8'd65;
      4'd7:    poll_addr = 8'd66;
      default: poll_addr = 8'd67;
    endcase
  endfunction

  // Transaction FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      is_poll     <= 1'b0;
      idx         <= 4'd0;
      wcnt        <= 8'd0;
      gcnt        <= 4'd0;
      cmd_ready   <= 1'b1;
      cs          <= 1'b0;
      writestrobe <= 1'b0;
      readstrobe  <= 1'b0;
      dir         <= 8'd0;
      dato        <= 8'd0;
      rd_data     <= 8'd0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      shadow      <= 72'd0;
    end else begin
      done        <= 1'b0;
      writestrobe <= 1'b0;
      readstrobe  <= 1'b0;
      case (state)
        S_IDLE: begin
          // Host command wins over a same-cycle poll_start, which is dropped.
          if (cmd_valid) begin
            is_write  <= cmd_write;
            is_poll   <= 1'b0;
            dir       <= cmd_addr;
            dato      <= cmd_data;
            error     <= 1'b0;
            cs        <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_SETUP;
          end else if (poll_start) begin
            is_write  <= 1'b0;
            is_poll   <= 1'b1;
            idx       <= 4'd0;
            dir       <= poll_addr(4'd0);
            error     <= 1'b0;
            cs        <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          // cs has been seen for a cycle; fire the single strobe.
          writestrobe <= is_write;
          readstrobe  <= ~is_write;
          state       <= S_STROBE;
        end
        S_STROBE: begin
          wcnt  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Response in the last timeout cycle still counts as success.
          if (rsp_valid) begin
            if (!is_write) begin
              if (is_poll) shadow[{idx, 3'b000} +: 8] <= dato_in;
              else         rd_data <= dato_in;
            end
            cs    <= 1'b0;
            state <= S_RELEASE;
          end else if (wcnt == TO_LAST) begin
            error <= 1'b1;
            cs    <= 1'b0;
            state <= S_RELEASE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_RELEASE: begin
          gcnt  <= 4'd0;
          state <= S_GAPWAIT;
        end
        S_GAPWAIT: begin
          if (gcnt == GAP_LAST) begin
            // A timeout aborts the remainder of a sweep.
            if (is_poll && (idx < 4'd8) && !error) begin
              idx   <= idx + 4'd1;
              dir   <= poll_addr(idx + 4'd1);
              cs    <= 1'b1;
              state <= S_SETUP;
            end else begin
              done      <= 1'b1;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: begin
          cs        <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/iniciador_bus_rtc.md
Name: iniciador_bus_rtc

Overview:
Bus initiator for the RTC register port. It drives cs / writestrobe / readstrobe / dir / dato toward the RTC control responder, waits for the responder's completion handshake, and returns read data. It has two modes. Single transactions are issued by a host command interface. Auto-poll mode reads the nine time/date registers (addresses 33-38 and 65-67) into a shadow bank used by the display path.

Parameters:
TIMEOUT, 255, max cycles spent in WAIT before the transaction is aborted with error (8-bit counter, 1..255)
GAP, 2, idle cycles with cs=0 forced between consecutive transactions (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  host requests a single transaction
cmd_write  in  1  1=write, 0=read
cmd_addr  in  8  target register address
cmd_data  in  8  write data
cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid & cmd_ready
poll_start  in  1  one-cycle pulse; starts an auto-poll sweep (ignored unless IDLE)
rsp_valid  in  1  responder completion flag (1 cycle or held)
dato_in  in  8  read data from responder, valid when rsp_valid=1
cs  out  1  chip select to responder
writestrobe  out  1  write strobe, one cycle
readstrobe  out  1  read strobe, one cycle
dir  out  8  address to responder
dato  out  8  write data to responder
rd_data  out  8  last single-read result
done  out  1  one-cycle pulse at the end of a single command or a whole sweep
error  out  1  sticky timeout flag; cleared by the next accepted command or poll_start
busy  out  1  high whenever state != IDLE
shadow  out  72  poll bank; byte k = register list[k]; list = 33,34,35,36,37,38,65,66,67 (k=0..8)

Behaviour:
- Reset (also mid-transaction): state=IDLE, all outputs 0 except cmd_ready=1. shadow=0, gap counter=0. A transaction in flight is abandoned with no done pulse. cs drops on the same edge.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states:
  - IDLE
  - SETUP: cs=1; dir/dato stable; strobes 0.
  - STROBE: cs=1; exactly one of writestrobe/readstrobe = 1 for exactly one cycle.
  - WAIT: cs=1; strobes 0; timeout counter runs.
  - RELEASE: cs=0.
  - GAPWAIT: cs=0; waits GAP cycles.
- IDLE transitions:
  - cmd_valid=1 -> SETUP (single mode). Latch write, addr and data.
  - else poll_start=1 -> SETUP (poll mode). Index=0, dir=33, read.
  - cmd_valid has priority over a same-cycle poll_start; the dropped poll_start is lost.
- SETUP -> STROBE unconditionally. The responder samples cs one cycle before the strobe.
- STROBE -> WAIT unconditionally. The timeout counter is cleared on entry.
- WAIT:
  - rsp_valid=1 -> RELEASE. On a read, capture dato_in that same cycle: into rd_data in single mode, into shadow byte[index] in poll mode.
  - Counter reaching TIMEOUT with no rsp_valid -> RELEASE with error=1. No data is written.
  - A rsp_valid arriving in the same cycle as the timeout counts as success.
- RELEASE -> GAPWAIT. cs=0 from this cycle onward. dir/dato are held.
- GAPWAIT: after GAP cycles:
  - single mode: done pulse, then IDLE.
  - poll mode with index<8: index+1, dir=list[index], then SETUP.
  - poll mode with index=8 or an error: done pulse, then IDLE.
  - A timeout aborts the rest of the sweep; shadow bytes already read are kept.
- Latency: a single transaction takes 3 + W + 1 + GAP cycles from acceptance to done, where W is the number of WAIT cycles up to and including the cycle with rsp_valid.
- rsp_valid outside WAIT is ignored. cmd_valid and poll_start while busy are ignored; no queueing.
- The index counter is 4 bits. It never wraps past 8.

Test Plan:
- Single write: cmd_write=1, addr=34, data=0x59, responder asserts rsp_valid 3 cycles after the strobe -> cs high for exactly 5 cycles, one writestrobe pulse with dir=34 and dato=0x59, done 1+GAP cycles later, error=0.
- Single read: addr=10, responder returns 0xA5 with rsp_valid -> rd_data=0xA5, readstrobe pulsed once, writestrobe never high.
- Poll sweep: poll_start, responder returns 0x10+k for the k-th read -> nine transactions at dirs 33..38, 65..67 in order, each separated by ≥GAP cs-low cycles; shadow=0x18_17_16_15_14_13_12_11_10 (byte 8..0); exactly one done.
- Timeout: TIMEOUT=8, no rsp_valid -> cs drops after 8 WAIT cycles, error=1, done pulses, rd_data unchanged; next cmd accepted clears error.
- Poll abort: the responder stalls on the 4th read (dir=36) -> shadow bytes 0-2 updated, bytes 3-8 keep prior values, error=1, one done.
- Reset mid-WAIT plus simultaneous cmd_valid/poll_start -> reset: cs=0 next edge, no done, cmd_ready=1; the following same-cycle cmd_valid+poll_start executes only the command.
